hdmi_tmds_encoder: RTL
======================

// Module: hdmi_tmds_encoder
// PURPOSE
//  Transmit-side TMDS encoder for the HDMI/DVI path: converts 8-bit R/G/B
//  pixels plus sync/control into three 10-bit TMDS words per pixel clock.
//  Output feeds the serializers; the receive-side word-lock logic aligns on
//  the control tokens generated here.
//  Fixed pipeline, one word per channel per clock, with a DC-balance counter.
// PARAMETERS
//  OPT_REGISTER_INPUT  1'b0  1: add input register stage (latency 3, else 2)
//  OPT_DVI             1'b1  1: force i_ctl to 0 (DVI mode); 0: pass i_ctl
// PORTS
//  i_pix_clk  in   1   pixel clock; the only clock
//  i_reset_n  in   1   reset, asynchronous, active low
//  i_de       in   1   1 = active video, encode pixel; 0 = control period
//  i_hsync    in   1   blue-channel C0 during control
//  i_vsync    in   1   blue-channel C1 during control
//  i_ctl      in   4   {C3,C2} red, {C1,C0} green control bits
//  i_r,i_g,i_b in  8   pixel data, sampled when i_de=1
//  o_r,o_g,o_b out 10  TMDS words; bit 0 is transmitted first
//  o_debug    out 32   {2'b0,cnt_r[4:0],3'b0,cnt_g[4:0],3'b0,cnt_b[4:0],9'b0}
// BEHAVIOUR
//  Reset (async assert, sync release): all pipeline regs clear; o_r/o_g/o_b
//   = 10'h354 (token C=00); disparity counters = 0; o_debug = 0.
//  Latency: inputs at edge n appear at outputs at edge n+2 (n+3 if
//   OPT_REGISTER_INPUT). i_de and control bits are delayed in lockstep.
//  Stage 1 (per channel, d = 8-bit pixel): n1 = popcount(d).
//   If n1>4 or (n1==4 and d[0]==0): q_m[0]=d[0], q_m[i]=~(q_m[i-1]^d[i]),
//   q_m[8]=0. Else q_m[i]=q_m[i-1]^d[i], q_m[8]=1. Register q_m, de, ctl.
//  Stage 2 (video, de=1): N1=popcount(q_m[7:0]), N0=8-N1, cnt signed 5-bit.
//   a) cnt==0 or N1==N0: out={~q_m[8],q_m[8],q_m[8]?q_m[7:0]:~q_m[7:0]};
//      cnt += q_m[8] ? N1-N0 : N0-N1.
//   b) (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out={1,q_m[8],~q_m[7:0]};
//      cnt += 2*q_m[8] + N0-N1.
//   c) otherwise: out={0,q_m[8],q_m[7:0]}; cnt += -2*~q_m[8] + N1-N0.
//  Stage 2 (control, de=0): cnt <= 0; out = token(C1,C0):
//   00->10'h354, 01->10'h0AB, 10->10'h154, 11->10'h2AB.
//   Blue C={vsync,hsync}; green C=ctl[1:0]; red C=ctl[3:2] (0 if OPT_DVI).
//  i_de=1 with syncs asserted: video wins, syncs ignored for that pixel.
//  DE 1->0: first control word resets cnt; DE 0->1: video starts at cnt=0.
//  Invariant: |cnt| <= 8 always; 5-bit arithmetic never overflows.
//  Channels independent; identical logic instantiated three times.
//  Reset mid-line: outputs go to 10'h354 immediately (async); first valid
//   word after release follows the latency above.
// TESTING
//  1 Reset held, random inputs -> o_r=o_g=o_b=10'h354, o_debug=0; still
//    10'h354 for 2 clocks after release with i_de=0, syncs 0.
//  2 i_de=0, {vsync,hsync}=00,01,10,11 -> o_b 10'h354,0AB,154,2AB two
//    clocks later; o_g/o_r stay 10'h354 (OPT_DVI=1).
//  3 Line start, i_b=8'h00 for 10 clocks -> o_b 100,3FF,100,3FF,...;
//    cnt_b sequence -8,2,-6,4,-4,6,-2,8,0.
//  4 Line start, i_g=8'hFF -> first o_g=10'h200, cnt_g=-8; then i_de=0
//    -> cnt_g=0 and o_g a control token on the next output word.
//  5 Random pixels, random DE gaps, 1e5 clocks -> software-model match
//    every word, |cnt|<=8; decode(o) == input pixel.
//  6 i_reset_n pulsed low mid-line -> outputs 10'h354 same cycle, cnt=0.

Source files
------------

// File: rtl/hdmi_tmds_encoder.sv
// hdmi_tmds_encoder: three-channel TMDS encoder (blue, green, red) for the
// HDMI/DVI transmit path. Stage 1 holds the transition-minimised word q_m;
// stage 2 applies DC balancing to video or emits a control token. An optional
// input register adds one cycle of latency ahead of stage 1.
module hdmi_tmds_encoder #(
    parameter bit OPT_REGISTER_INPUT = 1'b0,
    parameter bit OPT_DVI            = 1'b1
) (
    input  logic        i_pix_clk,
    input  logic        i_reset_n,
    input  logic        i_de,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [3:0]  i_ctl,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    output logic [9:0]  o_r,
    output logic [9:0]  o_g,
    output logic [9:0]  o_b,
    output logic [31:0] o_debug
);
    localparam logic [9:0] TOKEN_00 = 10'h354;
    localparam logic [9:0] TOKEN_01 = 10'h0AB;
    localparam logic [9:0] TOKEN_10 = 10'h154;
    localparam logic [9:0] TOKEN_11 = 10'h2AB;

    // Channel order in the packed arrays: index 0 = blue, 1 = green, 2 = red.
    logic [3:0]      ctl_eff;
    logic [2:0][7:0] pix_in;
    logic [2:0][1:0] c_in;
    logic            de_a;
    logic [2:0][7:0] pix_a;
    logic [2:0][1:0] c_a;
    logic            de_s1;
    logic [2:0][9:0] word_all;
    logic [2:0][4:0] cnt_all;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, d[i]};
        return n;
    endfunction

    // Transition minimisation: XNOR chain when the byte is 1-heavy, else XOR.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8]     = ~use_xnor;
        return q;
    endfunction

    // DVI mode has no red/green control bits; they are tied low here.
    assign ctl_eff = i_ctl & {4{~OPT_DVI}};
    assign pix_in  = {i_r, i_g, i_b};
    assign c_in    = {ctl_eff[3:2], ctl_eff[1:0], i_vsync, i_hsync};

    generate
        if (OPT_REGISTER_INPUT) begin : g_in_reg
            // Optional input register; all fields delayed together
            always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    de_a  <= 1'b0;
                    pix_a <= '0;
                    c_a   <= '0;
                end else begin
                    de_a  <= i_de;
                    pix_a <= pix_in;
                    c_a   <= c_in;
                end
            end
        end else begin : g_in_comb
            assign de_a  = i_de;
            assign pix_a = pix_in;
            assign c_a   = c_in;
        end
    endgenerate

    // Stage 1: video-enable travels in lockstep with q_m
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) de_s1 <= 1'b0;
        else            de_s1 <= de_a;
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [8:0]        qm_s1;
        logic [1:0]        c_s1;
        logic [3:0]        n1_q;
        logic signed [4:0] diff;
        logic signed [4:0] cnt_q;
        logic signed [4:0] cnt_d;
        logic [9:0]        word_q;
        logic [9:0]        word_d;

        // Stage 1: register the transition-minimised word and control bits
        always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                qm_s1 <= '0;
                c_s1  <= '0;
            end else begin
                qm_s1 <= tmds_qm(pix_a[ch]);
                c_s1  <= c_a[ch];
            end
        end

        assign n1_q = popcount8(qm_s1[7:0]);
        // N1 - N0 = 2*N1 - 8; range -8..8 fits 5-bit two's complement
        assign diff = $signed({n1_q, 1'b0} - 5'd8);

        // Stage 2 next state: control token, or DC-balanced video word
        always_comb begin
            word_d = TOKEN_00;
            cnt_d  = cnt_q;
            if (!de_s1) begin
                cnt_d = 5'sd0;
                case (c_s1)
                    2'b00:   word_d = TOKEN_00;
                    2'b01:   word_d = TOKEN_01;
                    2'b10:   word_d = TOKEN_10;
                    default: word_d = TOKEN_11;
                endcase
            end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
                word_d = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
                cnt_d  = qm_s1[8] ? (cnt_q + diff) : (cnt_q - diff);
            end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                         ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
                word_d = {1'b1, qm_s1[8], ~qm_s1[7:0]};
                cnt_d  = cnt_q + (qm_s1[8] ? 5'sd2 : 5'sd0) - diff;
            end else begin
                word_d = {1'b0, qm_s1[8], qm_s1[7:0]};
                cnt_d  = cnt_q - (qm_s1[8] ? 5'sd0 : 5'sd2) + diff;
            end
        end

        // Stage 2: output word and running disparity
        always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                word_q <= TOKEN_00;
                cnt_q  <= 5'sd0;
            end else begin
                word_q <= word_d;
                cnt_q  <= cnt_d;
            end
        end

        assign word_all[ch] = word_q;
        assign cnt_all[ch]  = cnt_q;
    end

    assign o_b     = word_all[0];
    assign o_g     = word_all[1];
    assign o_r     = word_all[2];
    assign o_debug = {2'b00, cnt_all[2], 3'b000, cnt_all[1], 3'b000, cnt_all[0], 9'd0};

endmodule
